// File: rtl/fetch_queue_pkg.sv
// Shared sizes and the queue entry type for the fetch->decode instruction buffer.
package cpu_sizes;
    localparam int INSTR_WINDOW = 2;
    localparam int XLEN         = 32;
    localparam int POP_W        = $clog2(INSTR_WINDOW + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue_compact.sv
// Squeezes the masked slots of one fetch window into consecutive entries, oldest first.
module fq_compact
    import cpu_sizes::*;
(
    input  logic      [INSTR_WINDOW-1:0]            mask_i,
    input  logic      [INSTR_WINDOW-1:0][XLEN-1:0]  pc_i,
    input  logic      [INSTR_WINDOW-1:0][XLEN-1:0]  instr_i,
    output fq_entry_t [INSTR_WINDOW-1:0]            entries_o,
    output logic      [POP_W-1:0]                   count_o
);

    logic [POP_W-1:0] slot;

    // Each valid slot lands at the next free output position, keeping program order.
    always_comb begin
        entries_o = '0;
        slot      = '0;
        for (int i = 0; i < INSTR_WINDOW; i++) begin
            if (mask_i[i]) begin
                for (int j = 0; j < INSTR_WINDOW; j++) begin
                    if (slot == POP_W'(j)) begin
                        entries_o[j].pc    = pc_i[i];
                        entries_o[j].instr = instr_i[i];
                    end
                end
                slot = slot + POP_W'(1);
            end
        end
        count_o = slot;
    end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode; push a compacted window,
// pop up to INSTR_WINDOW oldest entries, flush on redirect.
module fetch_queue
    import cpu_sizes::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                CLK,
    input  logic                                RESET_N,
    input  logic                                FQ_IN_VALID,
    input  logic [INSTR_WINDOW-1:0]             FQ_IN_MASK,
    input  logic [INSTR_WINDOW-1:0][XLEN-1:0]   FQ_IN_PC,
    input  logic [INSTR_WINDOW-1:0][XLEN-1:0]   FQ_IN_INSTR,
    output logic                                FQ_IN_READY,
    input  logic                                FLUSH,
    output logic [INSTR_WINDOW-1:0]             DEC_VALID,
    output logic [INSTR_WINDOW-1:0][XLEN-1:0]   DEC_PC,
    output logic [INSTR_WINDOW-1:0][XLEN-1:0]   DEC_INSTR,
    input  logic [POP_W-1:0]                    DEC_POP,
    output logic [$clog2(DEPTH+1)-1:0]          FQ_COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fq_entry_t                      entries_q [DEPTH];
    logic      [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
    logic      [CNT_W-1:0]          count_q, count_d;
    logic      [CNT_W-1:0]          popReq, effPop, pushCnt;
    fq_entry_t [INSTR_WINDOW-1:0]   packedWin;
    logic      [POP_W-1:0]          winCnt;
    logic                           pushFire;

    fq_compact uCompact (
        .mask_i    (FQ_IN_MASK),
        .pc_i      (FQ_IN_PC),
        .instr_i   (FQ_IN_INSTR),
        .entries_o (packedWin),
        .count_o   (winCnt)
    );

    // Ready looks only at registered occupancy, so a same-cycle pop never grants space.
    assign FQ_IN_READY = (count_q <= CNT_W'(DEPTH - INSTR_WINDOW));
    assign pushFire    = FQ_IN_VALID && FQ_IN_READY && !FLUSH;
    assign popReq      = CNT_W'(DEC_POP);
    assign effPop      = (popReq > count_q) ? count_q : popReq;
    assign pushCnt     = pushFire ? CNT_W'(winCnt) : '0;
    assign FQ_COUNT    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (FLUSH) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(effPop);
            tail_d  = tail_q + PTR_W'(pushCnt);
            count_d = count_q + pushCnt - effPop;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries_q[k] <= '0;
            end
        end else if (pushFire) begin
            for (int j = 0; j < INSTR_WINDOW; j++) begin
                if (POP_W'(j) < winCnt) begin
                    entries_q[tail_q + PTR_W'(j)] <= packedWin[j];
                end
            end
        end
    end

    // Head read mux; DEC_* reflect registered state only.
    always_comb begin
        DEC_VALID = '0;
        DEC_PC    = '0;
        DEC_INSTR = '0;
        for (int i = 0; i < INSTR_WINDOW; i++) begin
            DEC_VALID[i] = (CNT_W'(i) < count_q);
            DEC_PC[i]    = entries_q[head_q + PTR_W'(i)].pc;
            DEC_INSTR[i] = entries_q[head_q + PTR_W'(i)].instr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET_N && !FLUSH) begin
            assert (popReq <= count_q)
            else $warning("fetch_queue: DEC_POP %0d exceeds occupancy %0d, clamped", popReq, count_q);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue: stimulus queues expected post-edge state,
// a negedge monitor pops and compares.
module tb_fetch_queue;
    import cpu_sizes::*;

    typedef struct {
        string       tag;
        logic [2:0]  cnt;
        logic [1:0]  vld;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        rdy;
    } exp_t;

    logic                          clk;
    logic                          rstN;
    logic                          inValid;
    logic [INSTR_WINDOW-1:0]       inMask;
    logic [INSTR_WINDOW-1:0][31:0] inPc;
    logic [INSTR_WINDOW-1:0][31:0] inInstr;
    logic                          inReady;
    logic                          flush;
    logic [INSTR_WINDOW-1:0]       decValid;
    logic [INSTR_WINDOW-1:0][31:0] decPc;
    logic [INSTR_WINDOW-1:0][31:0] decInstr;
    logic [POP_W-1:0]              decPop;
    logic [2:0]                    fqCount;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    exp_t monExp;

    fetch_queue #(.DEPTH(4)) dut (
        .CLK         (clk),
        .RESET_N     (rstN),
        .FQ_IN_VALID (inValid),
        .FQ_IN_MASK  (inMask),
        .FQ_IN_PC    (inPc),
        .FQ_IN_INSTR (inInstr),
        .FQ_IN_READY (inReady),
        .FLUSH       (flush),
        .DEC_VALID   (decValid),
        .DEC_PC      (decPc),
        .DEC_INSTR   (decInstr),
        .DEC_POP     (decPop),
        .FQ_COUNT    (fqCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return 32'hC0DE_0000 | pc;
    endfunction

    task automatic cmpVal(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, want);
        end
    endtask

    // Compares occupancy, valid and ready always; pc/instr only for valid slots unless strict.
    task automatic checkOutput(input exp_t e, input bit strict);
        cmpVal({e.tag, ".count"}, 32'(fqCount), 32'(e.cnt));
        cmpVal({e.tag, ".valid"}, 32'(decValid), 32'(e.vld));
        cmpVal({e.tag, ".ready"}, 32'(inReady), 32'(e.rdy));
        if (e.vld[0] || strict) begin
            cmpVal({e.tag, ".pc0"}, decPc[0], e.pc0);
            cmpVal({e.tag, ".instr0"}, decInstr[0], strict ? 32'h0 : instrOf(e.pc0));
        end
        if (e.vld[1] || strict) begin
            cmpVal({e.tag, ".pc1"}, decPc[1], e.pc1);
            cmpVal({e.tag, ".instr1"}, decInstr[1], strict ? 32'h0 : instrOf(e.pc1));
        end
    endtask

    task automatic applyStimulus(input string tag, input logic v, input logic [1:0] m,
                                 input logic [31:0] p0, input logic [31:0] p1,
                                 input logic [1:0] pop, input logic fl,
                                 input logic [2:0] eCnt, input logic [1:0] eVld,
                                 input logic [31:0] e0, input logic [31:0] e1, input logic eRdy);
        exp_t e;
        inValid    = v;
        inMask     = m;
        inPc[0]    = p0;
        inPc[1]    = p1;
        inInstr[0] = instrOf(p0);
        inInstr[1] = instrOf(p1);
        decPop     = pop;
        flush      = fl;
        @(posedge clk);
        e.tag = tag; e.cnt = eCnt; e.vld = eVld; e.pc0 = e0; e.pc1 = e1; e.rdy = eRdy;
        expQ.push_back(e);
        #1;
        inValid = 1'b0;
        inMask  = '0;
        decPop  = '0;
        flush   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput(monExp, 1'b0);
        end
    end

    initial begin
        exp_t z;
        z.tag = "reset"; z.cnt = 3'd0; z.vld = 2'b00; z.pc0 = 32'h0; z.pc1 = 32'h0; z.rdy = 1'b1;
        rstN = 1'b0; inValid = 1'b0; inMask = '0; inPc = '0; inInstr = '0; decPop = '0; flush = 1'b0;
        #3;
        checkOutput(z, 1'b1);
        #4 rstN = 1'b1;

        applyStimulus("push1",  1, 2'b11, 32'h00, 32'h04, 0, 0, 3'd2, 2'b11, 32'h00, 32'h04, 1);
        applyStimulus("push2",  1, 2'b11, 32'h08, 32'h0C, 0, 0, 3'd4, 2'b11, 32'h00, 32'h04, 0);
        applyStimulus("held",   1, 2'b11, 32'h10, 32'h14, 0, 0, 3'd4, 2'b11, 32'h00, 32'h04, 0);
        applyStimulus("popA",   1, 2'b11, 32'h10, 32'h14, 2, 0, 3'd2, 2'b11, 32'h08, 32'h0C, 1);
        applyStimulus("popB",   1, 2'b11, 32'h10, 32'h14, 2, 0, 3'd2, 2'b11, 32'h10, 32'h14, 1);
        applyStimulus("popC",   1, 2'b01, 32'h18, 32'h1C, 2, 0, 3'd1, 2'b01, 32'h18, 32'h00, 1);
        applyStimulus("mask10", 1, 2'b10, 32'h18, 32'h1C, 1, 0, 3'd1, 2'b01, 32'h1C, 32'h00, 1);
        applyStimulus("mask00", 1, 2'b00, 32'h18, 32'h1C, 0, 0, 3'd1, 2'b01, 32'h1C, 32'h00, 1);
        applyStimulus("push3",  1, 2'b11, 32'h20, 32'h24, 0, 0, 3'd3, 2'b11, 32'h1C, 32'h20, 0);
        applyStimulus("flush",  1, 2'b11, 32'h30, 32'h34, 1, 1, 3'd0, 2'b00, 32'h00, 32'h00, 1);
        applyStimulus("refill", 1, 2'b11, 32'h40, 32'h44, 0, 0, 3'd2, 2'b11, 32'h40, 32'h44, 1);
        applyStimulus("push48", 1, 2'b01, 32'h48, 32'h4C, 0, 0, 3'd3, 2'b11, 32'h40, 32'h44, 0);

        @(negedge clk);
        #1 rstN = 1'b0;
        #1;
        z.tag = "asyncReset";
        checkOutput(z, 1'b1);
        #1 rstN = 1'b1;

        applyStimulus("clamp",     0, 2'b00, 32'h00, 32'h00, 2, 0, 3'd0, 2'b00, 32'h00, 32'h00, 1);
        applyStimulus("pushClamp", 1, 2'b11, 32'h50, 32'h54, 2, 0, 3'd2, 2'b11, 32'h50, 32'h54, 1);
        applyStimulus("pushPop",   1, 2'b11, 32'h58, 32'h5C, 1, 0, 3'd3, 2'b11, 32'h54, 32'h58, 0);

        repeat (2) @(negedge clk);
        #1;
        cmpVal("drain", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
